// File: rtl/fifo_uart_drain_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_drain_pkg
// Shared definitions for the FIFO-to-UART drain block: the UART FSM state
// encoding, the frame data width and the default parameter values.
// No ports (package).
// -----------------------------------------------------------------------------
package fifo_uart_drain_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_DEPTH        = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

endpackage

// File: rtl/fifo_uart_drain_shadow_count.sv
// -----------------------------------------------------------------------------
// fifo_shadow_count
// Mirrors the occupancy of the upstream FIFO (which has no full/empty flags)
// by watching its write strobe and our own read strobe, and gates the read
// strobe so that it never hits an empty FIFO and never collides with a write.
//
// Ports:
//   clk       clock
//   rst_n     synchronous active-low reset (shared with the FIFO)
//   fifo_wen  copy of the FIFO write strobe
//   idle      high when the consumer is ready to accept a byte
//   fifo_ren  read strobe into the FIFO (combinational)
//   occ       shadow occupancy, 0..DEPTH
//   overflow  sticky: a write arrived while the FIFO was full
// -----------------------------------------------------------------------------
module fifo_shadow_count
    import fifo_uart_drain_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fifo_wen,
    input  logic                         idle,
    output logic                         fifo_ren,
    output logic [$clog2(DEPTH+1)-1:0]   occ,
    output logic                         overflow
);

    localparam int               OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL  = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] ONE   = OCC_W'(1);

    // The FIFO gives ren priority and drops a coincident write, so we back
    // off whenever the writer is active; that way no byte is ever lost.
    assign fifo_ren = idle && (occ != '0) && !fifo_wen;

    // Occupancy follows the FIFO's own rules: read wins, a write into a full
    // FIFO is dropped and only leaves the sticky overflow flag behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ      <= '0;
            overflow <= 1'b0;
        end else if (fifo_ren) begin
            occ <= occ - ONE;
        end else if (fifo_wen) begin
            if (occ == FULL) begin
                overflow <= 1'b1;
            end else begin
                occ <= occ + ONE;
            end
        end
    end

endmodule

// File: rtl/fifo_uart_drain.sv
// -----------------------------------------------------------------------------
// fifo_uart_drain
// Pulls bytes out of the 8-entry byte FIFO and sends each as an 8N1 UART
// frame (start bit, 8 data bits LSB first, stop bit).
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   fifo_wen   copy of the FIFO write strobe from the upstream writer
//   fifo_ren   read strobe into the FIFO
//   fifo_dout  FIFO read data, valid the cycle after fifo_ren
//   tx         UART line, idle high, registered
//   busy       high from READ through STOP
//   occ        shadow occupancy of the FIFO
//   overflow   sticky write-while-full indication
// -----------------------------------------------------------------------------
module fifo_uart_drain
    import fifo_uart_drain_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DEPTH        = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fifo_wen,
    output logic                        fifo_ren,
    input  logic [UART_DATA_BITS-1:0]   fifo_dout,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(DEPTH+1)-1:0]  occ,
    output logic                        overflow
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int               BIT_W    = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

    state_t                      state;
    state_t                      state_next;
    logic [CNT_W-1:0]            clk_cnt;
    logic [CNT_W-1:0]            clk_cnt_next;
    logic [BIT_W-1:0]            bit_idx;
    logic [BIT_W-1:0]            bit_idx_next;
    logic [UART_DATA_BITS-1:0]   shreg;
    logic                        tx_next;
    logic                        bit_done;
    logic                        idle;

    assign idle     = (state == IDLE);
    assign bit_done = (clk_cnt == CNT_LAST);

    fifo_shadow_count #(
        .DEPTH (DEPTH)
    ) u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .fifo_wen (fifo_wen),
        .idle     (idle),
        .fifo_ren (fifo_ren),
        .occ      (occ),
        .overflow (overflow)
    );

    // State register plus the frame datapath. The byte is captured at the end
    // of READ because the FIFO only presents dout the cycle after ren.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            clk_cnt <= clk_cnt_next;
            bit_idx <= bit_idx_next;
            tx      <= tx_next;
            if (state == READ) begin
                shreg <= fifo_dout;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fifo_ren) state_next = READ;
            READ:    state_next = START;
            START:   if (bit_done) state_next = DATA;
            DATA:    if (bit_done && (bit_idx == BIT_LAST)) state_next = STOP;
            STOP:    if (bit_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bit timing: the divider restarts on every state entry and wraps after
    // each data bit; the bit index naturally wraps 7->0 on the way to STOP.
    always_comb begin
        clk_cnt_next = '0;
        bit_idx_next = bit_idx;
        if ((state_next == state) && (state != IDLE)) begin
            clk_cnt_next = bit_done ? '0 : clk_cnt + CNT_W'(1);
        end
        if ((state == DATA) && bit_done) begin
            bit_idx_next = bit_idx + BIT_W'(1);
        end
    end

    // Outputs. tx is decoded from the state being entered so that the
    // registered line lines up exactly with the state it belongs to.
    always_comb begin
        busy    = (state != IDLE);
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg[bit_idx_next];
            default: tx_next = 1'b1;
        endcase
    end

endmodule
